// File: rtl/fpu_issue_ctrl_pkg.sv
// FPU issue controller shared definitions: op codes, compare-op decode and
// the issue FSM state type.
package fpu_pkg;

  localparam logic [2:0] FOP_ADD = 3'b000;
  localparam logic [2:0] FOP_SUB = 3'b001;
  localparam logic [2:0] FOP_CEQ = 3'b010;
  localparam logic [2:0] FOP_CNE = 3'b011;
  localparam logic [2:0] FOP_CLT = 3'b100;
  localparam logic [2:0] FOP_CLE = 3'b101;
  localparam logic [2:0] FOP_CGT = 3'b110;
  localparam logic [2:0] FOP_MOV = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } fsm_state_t;

  // Compare ops produce a condition code instead of a data result.
  function automatic logic is_cmp(input logic [2:0] op);
    logic r;
    case (op)
      FOP_ADD, FOP_SUB, FOP_MOV:                   r = 1'b0;
      FOP_CEQ, FOP_CNE, FOP_CLT, FOP_CLE, FOP_CGT: r = 1'b1;
      default:                                     r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fpu_issue_ctrl_arb.sv
// Round-robin arbiter: one-hot grant to the first valid requester at or
// after rr_ptr, wrapping around.
module fpu_rr_arb #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any_req
);

  // Scan requesters starting at the pointer; the first valid one wins.
  always_comb begin : scan
    int unsigned idx;
    logic [ID_W-1:0] idx_l;
    logic found;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    idx_l    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx   = (32'(rr_ptr) + i) % NUM_REQ;
      idx_l = ID_W'(idx);
      if (!found && req_valid[idx_l]) begin
        found        = 1'b1;
        grant[idx_l] = 1'b1;
        grant_id     = idx_l;
      end
    end
  end

  assign any_req = |req_valid;

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FPU issue controller: shares one combinational FPU between NUM_REQ
// requesters with round-robin arbitration, holds operands for EXEC_CYCLES,
// returns the result on a valid/ready port and maintains the FP condition
// flag. Optional macro FPU_ISSUE_PIPELINE_EN lets a new op be accepted in
// the same cycle a response is taken, skipping the IDLE bubble.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned EXEC_CYCLES = 2,
  parameter int unsigned ID_W        = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [3*NUM_REQ-1:0]  req_op,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic                  fpu_enable,
  output logic [2:0]            fpu_op,
  output logic [31:0]           fpu_a,
  output logic [31:0]           fpu_b,
  input  logic [31:0]           fpu_result,
  input  logic                  fpu_cc,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_result,
  output logic                  rsp_is_cmp,
  output logic                  fcc,
  output logic                  busy
);

  localparam int unsigned CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  fsm_state_t       state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  rr_next;
  logic [ID_W-1:0]  gnt_id;
  logic [NUM_REQ-1:0] grant;
  logic             any_req;
  logic             arb_en;
  logic             accept;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [ID_W-1:0]  id_q;
  logic [2:0]       sel_op;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;

  fpu_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_id  (gnt_id),
    .any_req   (any_req)
  );

`ifdef FPU_ISSUE_PIPELINE_EN
  assign arb_en = (state == IDLE) || ((state == RESP) && rsp_ready);
`else
  assign arb_en = (state == IDLE);
`endif

  assign req_ready = arb_en ? grant : '0;
  assign accept    = arb_en && any_req;
  assign rr_next   = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;

  assign fpu_enable = (state == EXEC);
  assign fpu_op     = op_q;
  assign fpu_a      = a_q;
  assign fpu_b      = b_q;
  assign busy       = (state != IDLE);

  // Route the granted requester's op and operands towards the latches.
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_op = req_op[3*i +: 3];
        sel_a  = req_a[32*i +: 32];
        sel_b  = req_b[32*i +: 32];
      end
    end
  end

  // Issue FSM: accept, hold operands for EXEC_CYCLES, capture, hand back.
  // Operand loading is keyed on accept rather than on state so the same
  // path serves both the IDLE grant and the RESP->EXEC pipelined grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      cnt        <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_is_cmp <= 1'b0;
      fcc        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) state <= EXEC;
        end
        EXEC: begin
          if (cnt == '0) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= id_q;
            rsp_is_cmp <= is_cmp(op_q);
            rsp_result <= is_cmp(op_q) ? {31'b0, fpu_cc} : fpu_result;
            if (is_cmp(op_q)) fcc <= fpu_cc;
            state <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= accept ? EXEC : IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        op_q   <= sel_op;
        a_q    <= sel_a;
        b_q    <= sel_b;
        id_q   <= gnt_id;
        rr_ptr <= rr_next;
        cnt    <= CNT_W'(EXEC_CYCLES - 1);
      end
    end
  end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Shares the single combinational FPU datapath between NUM_REQ requesters, e.g. the integer pipeline's COP1 issue stage and a debug/test port.
- Round-robin arbitration; the granted operation's operands are held stable for EXEC_CYCLES cycles so the FPU can settle.
- Captures the result on a valid/ready response port and maintains the architectural FP condition flag (fcc) used by bc1t/bc1f.

Parameters:
- NUM_REQ, 2: number of requesters; legal range 2..8.
- EXEC_CYCLES, 2: cycles operands are held on the FPU before the result is captured; must be >= 1.
- ID_W, 1: requester-ID width; must equal $clog2(NUM_REQ).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester grant/accept; one-hot or zero
- req_op  in  3*NUM_REQ  per-requester FPU op code (000 add, 001 sub, 010..110 compares, 111 mov)
- req_a  in  32*NUM_REQ  per-requester operand A (IEEE-754 single)
- req_b  in  32*NUM_REQ  per-requester operand B
- fpu_enable  out  1  FPU enable
- fpu_op  out  3  to FPU
- fpu_a  out  32  to FPU
- fpu_b  out  32  to FPU
- fpu_result  in  32  from FPU
- fpu_cc  in  1  from FPU
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  ID_W  requester that owns the response
- rsp_result  out  32  captured result; {31'b0, cc} for compares
- rsp_is_cmp  out  1  response came from a compare op
- fcc  out  1  architectural FP condition flag
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; rsp_valid=0, rsp_id=0, rsp_result=0, rsp_is_cmp=0, fcc=0.
  - Latched op/a/b=0; counter=0; RR pointer set so requester 0 has highest priority.
  - An in-flight op is dropped with no response.
- FSM IDLE:
  - If any req_valid, grant the first valid requester at or after rr_ptr (wrapping).
  - req_ready[g]=1 combinationally; handshake completes on the same edge.
  - Latch op/a/b/id; rr_ptr=(g+1) mod NUM_REQ; counter=EXEC_CYCLES-1; go to EXEC.
  - req_ready is never asserted outside IDLE, except under the optional feature.
- FSM EXEC:
  - fpu_enable=1; fpu_op/a/b driven from the latches and stable throughout.
  - Counter decrements each cycle. At counter==0 the edge captures the response into the rsp_* registers and moves to RESP.
  - rsp_result=fpu_result for 000/001/111, or {31'b0,fpu_cc} for 010..110.
  - On compare ops only, fcc<=fpu_cc on that edge.
- FSM RESP:
  - rsp_valid=1; rsp_* held stable until rsp_ready. On rsp_valid&rsp_ready go to IDLE.
- Outside EXEC: fpu_enable=0; fpu_op/a/b keep their last latched values.
- Latency: rsp_valid rises exactly EXEC_CYCLES edges after the accepting edge. Throughput is one op per EXEC_CYCLES+2 cycles (back-to-back, rsp_ready tied high).
- Fairness: with every req_valid held high, grants rotate 0,1,...,NUM_REQ-1.
- Request rules: a requester's req_valid may drop without a grant (no requirement to hold). Requests arriving during EXEC/RESP wait.
- fcc is unchanged by add/sub/mov and by reset release.

Optional Feature:
- Macro: FPU_ISSUE_PIPELINE_EN.
- Defined:
  - In RESP with rsp_ready=1 and any req_valid, arbitration runs in the same cycle (req_ready asserted) and the FSM goes RESP->EXEC directly, removing the IDLE bubble.
  - Throughput becomes one op per EXEC_CYCLES+1 cycles.
- Undefined: RESP always returns to IDLE.

Decomposition:
- Package fpu_pkg holds:
  - Op-code localparams (FOP_ADD=3'b000 ... FOP_MOV=3'b111).
  - is_cmp function (op in 010..110).
  - FSM state enum (IDLE, EXEC, RESP).
- Sub-module fpu_rr_arb (NUM_REQ parameter): combinational one-hot grant from req_valid and rr_ptr.
- The FPU itself is instantiated outside, by the parent.

Test Plan:
- Single add, EXEC_CYCLES=2: req0 op=000, a=0x3F800000, b=0x40000000 -> req_ready[0] pulses once; rsp_valid 2 edges later; rsp_result=0x40400000, rsp_id=0, fcc unchanged (0).
- Compare update: req1 op=100 (lt), a=1.0, b=2.0 -> rsp_result=1, rsp_is_cmp=1, fcc=1. Then op=110 (gt) with the same operands -> fcc=0.
- Round-robin: both req_valid held high, rsp_ready=1, 4 ops -> grant order 0,1,0,1; each grant EXEC_CYCLES+2 cycles apart (+1 with FPU_ISSUE_PIPELINE_EN).
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_* stable; req_ready stays 0 for the pending req0; accepted the cycle after rsp_ready rises.
- Reset mid-EXEC: assert reset one cycle after accept -> rsp_valid=0, busy=0, fcc=0 immediately. After release, the next grant goes to requester 0.
- mov.s: op=111, b=0xC0490FDB -> rsp_result=0xC0490FDB; fcc unchanged.
